// File: rtl/tube_readout.sv
// Purpose: trigger-driven drift-window sequencer that snapshots all tube counts and streams them out one tube per beat.
// Latency: first beat is valid WINDOW+2 cycles after the trigger edge, then one beat per cycle while out_ready is high.
// Backpressure: a beat is held stable while out_ready is low; triggers that arrive while busy are counted and dropped.
module tube_readout #(
  parameter int NUM_TUBES = 8,
  parameter int WINDOW    = 256
) (
  input  logic                   i_clk,
  input  logic                   i_clr_n,
  input  logic                   i_trigger,
  input  logic [NUM_TUBES*8-1:0] i_tube_data,
  output logic                   o_tube_clr,
  output logic                   o_gate_enable,
  output logic                   o_busy,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [5:0]             o_out_tube,
  output logic [7:0]             o_out_count,
  output logic                   o_out_hit,
  output logic                   o_out_last,
  output logic [7:0]             o_out_event,
  output logic [7:0]             o_missed_count
);

  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_SEND} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_win;
  logic [NUM_TUBES*8-1:0] r_snap;
  logic                   r_tube_clr;
  logic                   r_gate_enable;
  logic                   r_busy;
  logic                   r_out_valid;
  logic [5:0]             r_out_tube;
  logic [7:0]             r_out_count;
  logic                   r_out_hit;
  logic                   r_out_last;
  logic [7:0]             r_out_event;
  logic [7:0]             r_missed_count;
  logic                   w_accept;
  logic [5:0]             w_nidx;
  logic [7:0]             w_ncount;

  assign w_accept = (r_state == S_SEND) && r_out_valid && i_out_ready;
  assign w_nidx   = r_out_tube + 6'd1;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; the window counter reaching WINDOW-1 marks the last ARM cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_trigger) w_next = S_ARM;
      S_ARM:     if (r_win == CW'(WINDOW - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (w_accept && r_out_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Snapshot lookup for the beat that follows the current one.
  always_comb begin
    w_ncount = 8'd0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      if (w_nidx == 6'(i)) w_ncount = r_snap[i*8 +: 8];
    end
  end

  // Registered outputs, window counter, snapshot and drop counter.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_tube_clr     <= 1'b1;
      r_gate_enable  <= 1'b0;
      r_busy         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_tube     <= 6'd0;
      r_out_count    <= 8'd0;
      r_out_hit      <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_event    <= 8'd0;
      r_missed_count <= 8'd0;
      r_win          <= '0;
      r_snap         <= '0;
    end else begin
      r_tube_clr    <= (w_next == S_IDLE);
      r_gate_enable <= (w_next == S_ARM);
      r_busy        <= (w_next != S_IDLE);
      r_out_valid   <= (w_next == S_SEND);

      if (r_state == S_ARM) r_win <= r_win + 1'b1;
      else                  r_win <= '0;

      if (i_trigger && (r_state != S_IDLE) && (r_missed_count != 8'hFF))
        r_missed_count <= r_missed_count + 8'd1;

      if (r_state == S_CAPTURE) begin
        r_snap      <= i_tube_data;
        r_out_event <= r_out_event + 8'd1;
        r_out_tube  <= 6'd0;
        r_out_count <= i_tube_data[7:0];
        r_out_hit   <= (i_tube_data[7:0] != 8'hFF);
        r_out_last  <= (NUM_TUBES == 1);
      end else if (w_accept) begin
        if (r_out_last) begin
          r_out_tube <= 6'd0;
          r_out_last <= 1'b0;
        end else begin
          r_out_tube  <= w_nidx;
          r_out_count <= w_ncount;
          r_out_hit   <= (w_ncount != 8'hFF);
          r_out_last  <= (w_nidx == 6'(NUM_TUBES - 1));
        end
      end
    end
  end

  assign o_tube_clr     = r_tube_clr;
  assign o_gate_enable  = r_gate_enable;
  assign o_busy         = r_busy;
  assign o_out_valid    = r_out_valid;
  assign o_out_tube     = r_out_tube;
  assign o_out_count    = r_out_count;
  assign o_out_hit      = r_out_hit;
  assign o_out_last     = r_out_last;
  assign o_out_event    = r_out_event;
  assign o_missed_count = r_missed_count;

endmodule

// File: tb/tb_tube_readout.sv
// Purpose: directed self-checking bench for tube_readout with a simple saturating tube-counter model.
// Latency: checks first beat at cycle WINDOW+2 after the trigger edge and one beat per accepted cycle.
// Backpressure: exercises out_ready stalls, dropped triggers and mid-flight resets.
module tb_tube_readout;

  localparam int NT  = 8;
  localparam int WIN = 256;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          trigger;
  logic [NT*8-1:0] tube_data;
  logic          tube_clr, gate_enable, busy, out_valid, out_ready;
  logic [5:0]    out_tube;
  logic [7:0]    out_count, out_event, missed_count;
  logic          out_hit, out_last;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  hits_en  = 1'b1;
  bit  scramble = 1'b0;
  logic [7:0] cnt;

  tube_readout #(.NUM_TUBES(NT), .WINDOW(WIN)) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_trigger(trigger), .i_tube_data(tube_data),
    .o_tube_clr(tube_clr), .o_gate_enable(gate_enable), .o_busy(busy),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_tube(out_tube),
    .o_out_count(out_count), .o_out_hit(out_hit), .o_out_last(out_last),
    .o_out_event(out_event), .o_missed_count(missed_count)
  );

  always #5 clk = ~clk;

  // Shared drift counter: cleared by tube_clr, counts while gated, saturates at 255.
  always @(posedge clk) begin
    if (tube_clr) cnt <= 8'd0;
    else if (gate_enable && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  // Tube i latches at count 10*i+5 when hits are enabled; scramble corrupts live data.
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      logic [7:0] hv, v;
      hv = 8'(10 * i + 5);
      v  = (hits_en && cnt >= hv) ? hv : cnt;
      tube_data[i*8 +: 8] = scramble ? ~v : v;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " tube_clr"}, tube_clr, 1);
    check({tag, " gate"}, gate_enable, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " valid"}, out_valid, 0);
    check({tag, " tube"}, out_tube, 0);
    check({tag, " count"}, out_count, 0);
    check({tag, " hit"}, out_hit, 0);
    check({tag, " last"}, out_last, 0);
    check({tag, " event"}, out_event, 0);
    check({tag, " missed"}, missed_count, 0);
  endtask

  // Called in cycle 1 (trigger just sampled); runs through ARM, CAPTURE and SEND and returns in the first IDLE cycle.
  task automatic readout(input logic [7:0] exp_ev, input bit stall, input bit arm_trigs, input bit trig_last);
    int b, k, guard;
    logic [3:0] pat;
    logic [7:0] exp_cnt;
    pat = 4'b1001;
    check("arm tube_clr", tube_clr, 0);
    check("arm gate", gate_enable, 1);
    check("arm busy", busy, 1);
    check("arm valid", out_valid, 0);
    for (int c = 1; c <= WIN; c++) begin
      trigger = arm_trigs && (c % 10 == 0) && (c <= 30);
      tick();
    end
    trigger = 1'b0;
    check("capture gate", gate_enable, 0);
    check("capture valid", out_valid, 0);
    check("capture busy", busy, 1);
    tick();
    scramble = 1'b1;
    b = 0; k = 0; guard = 0;
    while (b < NT && guard < 100) begin
      out_ready = stall ? pat[3 - (k % 4)] : 1'b1;
      exp_cnt = hits_en ? 8'(10 * b + 5) : 8'hFF;
      check("beat valid", out_valid, 1);
      check("beat tube", out_tube, b);
      check("beat count", out_count, exp_cnt);
      check("beat hit", out_hit, hits_en);
      check("beat last", out_last, b == NT - 1);
      check("beat event", out_event, exp_ev);
      trigger = trig_last && out_ready && (b == NT - 1);
      tick();
      trigger = 1'b0;
      if (out_ready) b++;
      k++; guard++;
    end
    if (guard >= 100) check("readout timeout", guard, 0);
    scramble  = 1'b0;
    out_ready = 1'b1;
    check("end valid", out_valid, 0);
    check("end tube_clr", tube_clr, 1);
    check("end busy", busy, 0);
  endtask

  task automatic fire();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  initial begin
    int guard;
    clr_n = 1'b0; trigger = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_reset_vals("reset");
    clr_n = 1'b1;
    tick();

    // Hits on every tube, free-flowing output.
    fire();
    readout(8'd1, 1'b0, 1'b0, 1'b0);

    // No hits: every tube saturates.
    hits_en = 1'b0;
    fire();
    readout(8'd2, 1'b0, 1'b0, 1'b0);
    hits_en = 1'b1;

    // Backpressure pattern 1,0,0,1.
    fire();
    readout(8'd3, 1'b1, 1'b0, 1'b0);
    check("missed after clean runs", missed_count, 0);

    // Dropped triggers, then a trigger in the first IDLE cycle.
    clr_n = 1'b0; tick(); clr_n = 1'b1; tick();
    fire();
    readout(8'd1, 1'b0, 1'b1, 1'b1);
    check("missed four", missed_count, 4);
    check("no extra event", busy, 0);
    fire();
    readout(8'd2, 1'b0, 1'b0, 1'b0);
    check("missed still four", missed_count, 4);

    // Reset in the middle of ARM.
    fire();
    repeat (50) tick();
    clr_n = 1'b0; tick();
    check_reset_vals("arm reset");
    clr_n = 1'b1; tick();

    // Reset in SEND while beat 3 is presented.
    fire();
    repeat (WIN + 1) tick();
    repeat (3) tick();
    check("pre-reset tube", out_tube, 3);
    clr_n = 1'b0; tick();
    check_reset_vals("send reset");
    clr_n = 1'b1; tick();
    fire();
    readout(8'd1, 1'b0, 1'b0, 1'b0);

    // Continuous trigger: event number wraps and missed count saturates.
    trigger = 1'b1;
    for (int e = 2; e <= 257; e++) begin
      guard = 0;
      while (!out_valid && guard < 400) begin tick(); guard++; end
      if (guard >= 400) check("wrap wait valid", guard, 0);
      if (e >= 254) check("wrap event", out_event, 32'(e[7:0]));
      guard = 0;
      while (out_valid && guard < 40) begin tick(); guard++; end
      if (guard >= 40) check("wrap wait done", guard, 0);
    end
    trigger = 1'b0;
    guard = 0;
    while (busy && guard < 400) begin tick(); guard++; end
    check("stress idle", busy, 0);
    check("missed saturated", missed_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
